// File: rtl/pc_fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: PC register, next-PC selection,
// IF/ID pipeline register and two saturating performance counters.
module pc_fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inPCSrc,
    input  logic [ADDR_W-1:0]  inBranchTarget,
    input  logic               inJump,
    input  logic [ADDR_W-1:0]  inJumpTarget,
    input  logic               inStall,
    input  logic [INSTR_W-1:0] inInstr,
    output logic [ADDR_W-1:0]  outPC,
    output logic [ADDR_W-1:0]  outIFID_PC4,
    output logic [INSTR_W-1:0] outIFID_Instr,
    output logic               outIFID_Valid,
    output logic [CNT_W-1:0]   outBranchCount,
    output logic [CNT_W-1:0]   outStallCount
);

    // The fetch mode is decided fresh every cycle from the hazard/ID inputs.
    typedef enum logic [1:0] {
        MODE_RUN,
        MODE_HOLD,
        MODE_REDIRECT
    } fetch_mode_e;

    fetch_mode_e        mode;
    logic [ADDR_W-1:0]  pc_plus4;
    logic [ADDR_W-1:0]  redirect_target;

    logic [ADDR_W-1:0]  pc_q,        pc_d;
    logic [ADDR_W-1:0]  ifid_pc4_q,  ifid_pc4_d;
    logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
    logic               ifid_valid_q, ifid_valid_d;
    logic [CNT_W-1:0]   branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q,  stall_cnt_d;

    // Priority stall > branch > jump > sequential; the branch target wins a tie with jump.
    always_comb begin
        mode            = MODE_RUN;
        pc_plus4        = pc_q + ADDR_W'(4);
        redirect_target = inPCSrc ? inBranchTarget : inJumpTarget;
        redirect_target = redirect_target & ~ADDR_W'(3);

        if (inStall) begin
            mode = MODE_HOLD;
        end else if (inPCSrc || inJump) begin
            mode = MODE_REDIRECT;
        end
    end

    // Next values for PC, IF/ID and the saturating counters.
    always_comb begin
        pc_d         = pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        branch_cnt_d = branch_cnt_q;
        stall_cnt_d  = stall_cnt_q;

        case (mode)
            MODE_HOLD: begin
                if (stall_cnt_q != '1) begin
                    stall_cnt_d = stall_cnt_q + CNT_W'(1);
                end
            end
            MODE_REDIRECT: begin
                pc_d         = redirect_target;
                ifid_pc4_d   = '0;
                ifid_instr_d = '0;
                ifid_valid_d = 1'b0;
                if (inPCSrc && (branch_cnt_q != '1)) begin
                    branch_cnt_d = branch_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                pc_d         = pc_plus4;
                ifid_pc4_d   = pc_plus4;
                ifid_instr_d = inInstr;
                ifid_valid_d = 1'b1;
            end
        endcase
    end

    // All state updates on the rising edge; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            ifid_pc4_q   <= '0;
            ifid_instr_q <= '0;
            ifid_valid_q <= 1'b0;
            branch_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            pc_q         <= pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            branch_cnt_q <= branch_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign outPC          = pc_q;
    assign outIFID_PC4    = ifid_pc4_q;
    assign outIFID_Instr  = ifid_instr_q;
    assign outIFID_Valid  = ifid_valid_q;
    assign outBranchCount = branch_cnt_q;
    assign outStallCount  = stall_cnt_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed, table-driven bench for pc_fetch_stage.
module tb_pc_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_pcsrc;
    logic [31:0] in_branch_target;
    logic        in_jump;
    logic [31:0] in_jump_target;
    logic        in_stall;
    logic [31:0] in_instr;
    logic [31:0] out_pc;
    logic [31:0] out_ifid_pc4;
    logic [31:0] out_ifid_instr;
    logic        out_ifid_valid;
    logic [15:0] out_branch_count;
    logic [15:0] out_stall_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [31:0] stall;
        logic [31:0] pcsrc;
        logic [31:0] btgt;
        logic [31:0] jump;
        logic [31:0] jtgt;
        logic [31:0] exp_pc;
        logic [31:0] exp_pc4;
        logic [31:0] exp_instr;
        logic [31:0] exp_valid;
        logic [31:0] exp_bcnt;
        logic [31:0] exp_scnt;
    } vec_t;

    vec_t vecs[17];

    pc_fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .inPCSrc        (in_pcsrc),
        .inBranchTarget (in_branch_target),
        .inJump         (in_jump),
        .inJumpTarget   (in_jump_target),
        .inStall        (in_stall),
        .inInstr        (in_instr),
        .outPC          (out_pc),
        .outIFID_PC4    (out_ifid_pc4),
        .outIFID_Instr  (out_ifid_instr),
        .outIFID_Valid  (out_ifid_valid),
        .outBranchCount (out_branch_count),
        .outStallCount  (out_stall_count)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Instruction memory model: the word at address A reads as 0x1111_0000 + A.
    assign in_instr = 32'h1111_0000 + out_pc;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%08h want=%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        in_stall         = v.stall[0];
        in_pcsrc         = v.pcsrc[0];
        in_branch_target = v.btgt;
        in_jump          = v.jump[0];
        in_jump_target   = v.jtgt;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input vec_t v);
        cmp({v.name, ".pc"},    out_pc,                  v.exp_pc);
        cmp({v.name, ".pc4"},   out_ifid_pc4,            v.exp_pc4);
        cmp({v.name, ".instr"}, out_ifid_instr,          v.exp_instr);
        cmp({v.name, ".valid"}, {31'd0, out_ifid_valid}, v.exp_valid);
        cmp({v.name, ".bcnt"},  {16'd0, out_branch_count}, v.exp_bcnt);
        cmp({v.name, ".scnt"},  {16'd0, out_stall_count},  v.exp_scnt);
    endtask

    task automatic idleInputs();
        in_stall         = 1'b0;
        in_pcsrc         = 1'b0;
        in_branch_target = '0;
        in_jump          = 1'b0;
        in_jump_target   = '0;
    endtask

    initial begin
        //            name          stall pcsrc btgt          jump jtgt          pc            pc4       instr         valid bcnt scnt
        vecs[0]  = '{"run0",        0, 0, 32'h0,        0, 32'h0,        32'h4,        32'h4,   32'h1111_0000, 1, 0, 0};
        vecs[1]  = '{"run1",        0, 0, 32'h0,        0, 32'h0,        32'h8,        32'h8,   32'h1111_0004, 1, 0, 0};
        vecs[2]  = '{"run2",        0, 0, 32'h0,        0, 32'h0,        32'hC,        32'hC,   32'h1111_0008, 1, 0, 0};
        vecs[3]  = '{"run3",        0, 0, 32'h0,        0, 32'h0,        32'h10,       32'h10,  32'h1111_000C, 1, 0, 0};
        vecs[4]  = '{"stall1",      1, 1, 32'h8,        0, 32'h0,        32'h10,       32'h10,  32'h1111_000C, 1, 0, 1};
        vecs[5]  = '{"stall2",      1, 1, 32'h8,        0, 32'h0,        32'h10,       32'h10,  32'h1111_000C, 1, 0, 2};
        vecs[6]  = '{"stall3",      1, 1, 32'h8,        0, 32'h0,        32'h10,       32'h10,  32'h1111_000C, 1, 0, 3};
        vecs[7]  = '{"unstall_br",  0, 1, 32'h8,        0, 32'h0,        32'h8,        32'h0,   32'h0,         0, 1, 3};
        vecs[8]  = '{"br_40",       0, 1, 32'h40,       0, 32'h0,        32'h40,       32'h0,   32'h0,         0, 2, 3};
        vecs[9]  = '{"after_br",    0, 0, 32'h0,        0, 32'h0,        32'h44,       32'h44,  32'h1111_0040, 1, 2, 3};
        vecs[10] = '{"br_and_jmp",  0, 1, 32'h80,       1, 32'h200,      32'h80,       32'h0,   32'h0,         0, 3, 3};
        vecs[11] = '{"jmp_unalign", 0, 0, 32'h0,        1, 32'h203,      32'h200,      32'h0,   32'h0,         0, 3, 3};
        vecs[12] = '{"after_jmp",   0, 0, 32'h0,        0, 32'h0,        32'h204,      32'h204, 32'h1111_0200, 1, 3, 3};
        vecs[13] = '{"jmp_top",     0, 0, 32'h0,        1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0,  32'h0,         0, 3, 3};
        vecs[14] = '{"wrap",        0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0,   32'h1110_FFFC, 1, 3, 3};
        vecs[15] = '{"br_unalign",  0, 1, 32'h13,       0, 32'h0,        32'h10,       32'h0,   32'h0,         0, 4, 3};
        vecs[16] = '{"stall_flush", 1, 0, 32'h0,        0, 32'h0,        32'h10,       32'h0,   32'h0,         0, 4, 4};

        // Reset state.
        idleInputs();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        cmp("rst.pc",    out_pc,                    32'h0);
        cmp("rst.pc4",   out_ifid_pc4,              32'h0);
        cmp("rst.instr", out_ifid_instr,            32'h0);
        cmp("rst.valid", {31'd0, out_ifid_valid},   32'h0);
        cmp("rst.bcnt",  {16'd0, out_branch_count}, 32'h0);
        cmp("rst.scnt",  {16'd0, out_stall_count},  32'h0);
        reset = 1'b0;

        // Main table.
        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i]);
        end

        // Reset asserted during a stall with nonzero counters.
        in_stall = 1'b1;
        in_pcsrc = 1'b1;
        in_branch_target = 32'h100;
        reset = 1'b1;
        @(posedge clk);
        #1;
        cmp("rst_mid.pc",    out_pc,                    32'h0);
        cmp("rst_mid.valid", {31'd0, out_ifid_valid},   32'h0);
        cmp("rst_mid.instr", out_ifid_instr,            32'h0);
        cmp("rst_mid.bcnt",  {16'd0, out_branch_count}, 32'h0);
        cmp("rst_mid.scnt",  {16'd0, out_stall_count},  32'h0);
        reset = 1'b0;
        idleInputs();

        // Stall counter saturation.
        in_stall = 1'b1;
        for (int i = 0; i < 65534; i++) begin
            @(posedge clk);
        end
        #1;
        cmp("sat.pre",  {16'd0, out_stall_count}, 32'hFFFE);
        @(posedge clk);
        #1;
        cmp("sat.hit",  {16'd0, out_stall_count}, 32'hFFFF);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
        end
        #1;
        cmp("sat.hold", {16'd0, out_stall_count}, 32'hFFFF);
        cmp("sat.pc",   out_pc,                   32'h0);
        cmp("sat.bcnt", {16'd0, out_branch_count}, 32'h0);

        // Release: first fetch after a long hold is the instruction at PC 0.
        in_stall = 1'b0;
        @(posedge clk);
        #1;
        cmp("post_sat.pc",    out_pc,                  32'h4);
        cmp("post_sat.instr", out_ifid_instr,          32'h1111_0000);
        cmp("post_sat.valid", {31'd0, out_ifid_valid}, 32'h1);
        cmp("post_sat.scnt",  {16'd0, out_stall_count}, 32'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_stage.md
Name: pc_fetch_stage

Overview:
IF stage of the 5-stage MIPS pipeline. It holds the PC, selects the next PC and owns the IF/ID pipeline register. It consumes the PCSrc decision from the ID-stage branch comparator, the jump request from the decoder and the stall request from the hazard unit. It also keeps two saturating performance counters: taken branches and stall cycles.

Parameters:
ADDR_W, 32, PC and target width (byte address)
INSTR_W, 32, instruction width
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_W, 16, performance counter width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high reset
inPCSrc  in  1  taken conditional branch (BEQ/BNE) resolved in ID
inBranchTarget  in  ADDR_W  branch target computed in ID
inJump  in  1  J/JAL decoded in ID
inJumpTarget  in  ADDR_W  jump target computed in ID
inStall  in  1  load-use stall from hazard unit
inInstr  in  INSTR_W  instruction memory read data for outPC (combinational read)
outPC  out  ADDR_W  current fetch address to instruction memory
outIFID_PC4  out  ADDR_W  IF/ID: PC+4 of fetched instruction
outIFID_Instr  out  INSTR_W  IF/ID: fetched instruction
outIFID_Valid  out  1  IF/ID: 1 = real instruction, 0 = bubble
outBranchCount  out  CNT_W  taken-branch count, saturating
outStallCount  out  CNT_W  stall-cycle count, saturating

Behaviour:
- Reset (sync, checked each edge, overrides everything, mid-operation included): outPC=RESET_PC; outIFID_PC4=0; outIFID_Instr=0 (NOP); outIFID_Valid=0; both counters=0; state=RUN.
- States: RUN, HOLD, REDIRECT. The state is re-evaluated every cycle from the inputs, in priority order stall > branch > jump > sequential:
  - HOLD, when inStall=1: outPC and the whole IF/ID register keep their values. inPCSrc and inJump are ignored, because the ID operands are not yet valid. outStallCount increments.
  - REDIRECT, when inStall=0 and (inPCSrc=1 or inJump=1): outPC gets the target. The target is inBranchTarget if inPCSrc=1, otherwise inJumpTarget. IF/ID is flushed: Instr=0, PC4=0, Valid=0. This wastes one slot. outBranchCount increments only if inPCSrc=1.
  - RUN, otherwise: outPC gets outPC+4. IF/ID gets PC4=outPC+4, Instr=inInstr, Valid=1.
- Simultaneous inPCSrc and inJump: the branch wins.
- Alignment: bits [1:0] of both targets are forced to 0 before loading.
- Arithmetic: PC+4 wraps modulo 2^ADDR_W, so 32'hFFFF_FFFC goes to 32'h0000_0000. There is no exception.
- Counters saturate at all-ones and never wrap.
- Latency: a redirect requested in cycle N appears on outPC in cycle N+1. The target instruction is valid in IF/ID in cycle N+2.
- The first edge after reset releases loads IF/ID with the instruction at RESET_PC (Valid=1), provided there is no stall or redirect.
- The state is internal only. All outputs are registered. There is no combinational path from any input to any output.

Test Plan:
- Reset then 4 free cycles, inInstr = 0x1111_0000+PC: outPC is 0x0, 0x4, 0x8, 0xC, 0x10. IF/ID Instr follows the PC one cycle behind with Valid=1. Counters stay 0.
- At PC=0x8, pulse inPCSrc=1 with inBranchTarget=0x40 for one cycle: next cycle outPC=0x40, Valid=0, Instr=0, outBranchCount=1. The cycle after, Instr=mem[0x40] and Valid=1.
- inStall=1 for 3 cycles at PC=0x10, with inPCSrc=1 held during the stall: outPC stays 0x10 and IF/ID is frozen. outStallCount=3, outBranchCount is unchanged. When the stall is released with inPCSrc still 1, the redirect is taken.
- inPCSrc=1 (target 0x80) and inJump=1 (target 0x200) in the same cycle: outPC=0x80, outBranchCount +1. Then inJump only with target 0x203: outPC=0x200, count unchanged.
- Start from PC=0xFFFF_FFFC (set by jump) and let it run one cycle: outPC=0x0000_0000, outIFID_PC4=0x0.
- Assert reset during a stall with counters nonzero: on the next edge outPC=RESET_PC, Valid=0 and both counters are 0. Preload outStallCount near 0xFFFF by running 65540 stall cycles: it holds at 0xFFFF.
